// File: rtl/fifo_rd_checker_if.sv
// FIFO read-port bundle between the read-side checker and the FIFO.
// The checker uses master and drives rd_en. The FIFO (or its model) uses slave.
interface fifo_rd_checker_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 9
);
    logic              empty;
    logic [CNT_W-1:0]  rd_data_count;
    logic [DATA_W-1:0] r_data;
    logic              rd_en;

    modport master (
        input  empty,
        input  rd_data_count,
        input  r_data,
        output rd_en
    );

    modport slave (
        output empty,
        output rd_data_count,
        output r_data,
        input  rd_en
    );
endinterface

// File: rtl/fifo_rd_checker.sv
// Read-side consumer and data checker for the dual-clock FIFO test path.
// After reset it waits out the FIFO recovery time. It then drains the FIFO
// in fixed-length bursts and checks every returned word against an
// incrementing sequence. Results are sticky flags and counters for ILA probing.
module fifo_rd_checker #(
    parameter int                DATA_W      = 16,
    parameter int                CNT_W       = 9,
    parameter int                INIT_WAIT   = 60,
    parameter int                BURST_LEN   = 64,
    parameter logic [DATA_W-1:0] START_VALUE = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_rd_checker_if.master fifo,
    output logic              burst_active,
    output logic              chk_valid,
    output logic              err,
    output logic [15:0]       err_cnt,
    output logic [31:0]       rd_total,
    output logic [DATA_W-1:0] bad_exp,
    output logic [DATA_W-1:0] bad_data
);

    localparam int WAIT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT - 1);
    localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        R_WAIT,
        R_IDLE,
        R_BURST
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]  beats_left, beats_left_nxt;
    logic              rd_en;
    logic              rd_en_d;
    logic [DATA_W-1:0] exp_val;

    // A read is accepted on every cycle in which rd_en is high.
    assign rd_en        = (state == R_BURST) & ~fifo.empty;
    assign fifo.rd_en   = rd_en;
    assign burst_active = (state == R_BURST);
    assign chk_valid    = rd_en_d;

    // Control registers: state, recovery-wait counter and burst beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= R_WAIT;
            wait_cnt   <= '0;
            beats_left <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            beats_left <= beats_left_nxt;
        end
    end

    // Next state: recovery wait, then a burst whenever enough words are queued.
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = '0;
        beats_left_nxt = beats_left;
        case (state)
            R_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = R_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            R_IDLE: begin
                if (fifo.rd_data_count >= BURST_CNT) begin
                    state_nxt      = R_BURST;
                    beats_left_nxt = BURST_CNT;
                end
            end
            R_BURST: begin
                if (rd_en) begin
                    beats_left_nxt = beats_left - CNT_W'(1);
                    if (beats_left == CNT_W'(1)) begin
                        state_nxt = R_IDLE;
                    end
                end
            end
            default: state_nxt = R_WAIT;
        endcase
    end

    // Data check one cycle after each accepted read. The expected value advances
    // on every checked word, so a single corrupted word costs exactly one error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_d  <= 1'b0;
            exp_val  <= START_VALUE;
            err      <= 1'b0;
            err_cnt  <= '0;
            rd_total <= '0;
            bad_exp  <= '0;
            bad_data <= '0;
        end else begin
            rd_en_d <= rd_en;
            if (rd_en_d) begin
                exp_val  <= exp_val + DATA_W'(1);
                rd_total <= rd_total + 32'd1;
                if (fifo.r_data != exp_val) begin
                    err <= 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                    if (!err) begin
                        bad_exp  <= exp_val;
                        bad_data <= fifo.r_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Testbench for fifo_rd_checker: a queue-based FIFO model feeds the checker.
// The bench predicts the results from the pushed word list and sequence arithmetic.
module tb_fifo_rd_checker;

    localparam int DATA_W    = 16;
    localparam int CNT_W     = 9;
    localparam int INIT_WAIT = 60;
    localparam int BURST_LEN = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;

    fifo_rd_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) if_a ();
    fifo_rd_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) if_b ();

    logic        ba_a, cv_a, err_a, ba_b, cv_b, err_b;
    logic [15:0] ec_a, ec_b, bexp_a, bexp_b, bdat_a, bdat_b;
    logic [31:0] tot_a, tot_b;

    fifo_rd_checker #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .INIT_WAIT(INIT_WAIT),
        .BURST_LEN(BURST_LEN), .START_VALUE(16'h0001)
    ) dut_a (
        .clk(clk), .rst_n(rst_a_n), .fifo(if_a),
        .burst_active(ba_a), .chk_valid(cv_a), .err(err_a), .err_cnt(ec_a),
        .rd_total(tot_a), .bad_exp(bexp_a), .bad_data(bdat_a)
    );

    fifo_rd_checker #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .INIT_WAIT(INIT_WAIT),
        .BURST_LEN(BURST_LEN), .START_VALUE(16'hFFFE)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .fifo(if_b),
        .burst_active(ba_b), .chk_valid(cv_b), .err(err_b), .err_cnt(ec_b),
        .rd_total(tot_b), .bad_exp(bexp_b), .bad_data(bdat_b)
    );

    int          total = 0;
    int          bad   = 0;
    bit          sel   = 1'b0;
    int          cyc = 0, rel_cyc = 0;
    int          rd_cnt = 0, chk_cnt = 0, first_rd = 0, last_rd = 0;
    int          drop = 0, viol = 0;
    logic        ba_post = 1'b0;
    logic [15:0] q[$];
    logic [15:0] sb[$];
    logic        fe = 1'b0, rstall = 1'b0;
    bit          rand_en = 1'b0;
    logic [15:0] m_start = 16'h0001;
    logic [15:0] word = '0;

    logic        o_rd_en, o_ba, o_cv, o_err;
    logic [15:0] o_ec, o_bexp, o_bdat;
    logic [31:0] o_tot;

    assign o_rd_en = sel ? if_b.rd_en : if_a.rd_en;
    assign o_ba    = sel ? ba_b   : ba_a;
    assign o_cv    = sel ? cv_b   : cv_a;
    assign o_err   = sel ? err_b  : err_a;
    assign o_ec    = sel ? ec_b   : ec_a;
    assign o_bexp  = sel ? bexp_b : bexp_a;
    assign o_bdat  = sel ? bdat_b : bdat_a;
    assign o_tot   = sel ? tot_b  : tot_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive the FIFO flags from the model queue and the stall controls.
    task automatic drive();
        logic             e;
        logic [CNT_W-1:0] c;
        e = fe | rstall | (q.size() == 0);
        c = (q.size() > 511) ? '1 : CNT_W'(q.size());
        if_a.empty = e;
        if_b.empty = e;
        if_a.rd_data_count = c;
        if_b.rd_data_count = c;
    endtask

    // One clock: sample pre-edge handshake, then update the FIFO model at edge+1.
    task automatic step();
        logic rd;
        @(posedge clk);
        cyc++;
        rd = o_rd_en;
        if (((rd_cnt % BURST_LEN) != 0) && !o_ba) drop++;
        if (o_cv) chk_cnt++;
        if (rd) begin
            if (if_a.empty) viol++;
            rd_cnt++;
            last_rd = cyc - rel_cyc;
            if (rd_cnt == 1) first_rd = last_rd;
        end
        #1;
        if (rd) begin
            if (q.size() > 0) word = q.pop_front();
            else viol++;
            if_a.r_data = word;
            if_b.r_data = word;
            ba_post = o_ba;
        end
        rstall = rand_en ? ($urandom_range(0, 5) == 0) : 1'b0;
        drive();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int n, input int budget);
        for (int i = 0; i < budget && rd_cnt < n; i++) step();
    endtask

    task automatic push(input logic [15:0] w);
        q.push_back(w);
        sb.push_back(w);
        drive();
    endtask

    task automatic reset_hold();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        q.delete();
        sb.delete();
        fe = 1'b0; rstall = 1'b0; rand_en = 1'b0;
        m_start = 16'h0001;
        rd_cnt = 0; chk_cnt = 0; first_rd = 0; last_rd = 0;
        drop = 0; viol = 0; ba_post = 1'b0; word = '0;
        if_a.r_data = '0;
        if_b.r_data = '0;
        drive();
        idle(3);
    endtask

    task automatic release_dut(input bit which);
        sel = which;
        if (which) rst_b_n = 1'b1;
        else       rst_a_n = 1'b1;
        rel_cyc = cyc;
    endtask

    // Reference: the first n pushed words against START + index.
    task automatic model_check(input string tag, input int n);
        int          m_err;
        bit          has;
        logic [15:0] e, bx, bd;
        m_err = 0; has = 1'b0; bx = '0; bd = '0;
        for (int i = 0; i < n && i < sb.size(); i++) begin
            e = m_start + 16'(i);
            if (sb[i] !== e) begin
                if (!has) begin
                    has = 1'b1; bx = e; bd = sb[i];
                end
                if (m_err < 65535) m_err++;
            end
        end
        chk({tag, " reads"},    rd_cnt,  n);
        chk({tag, " checks"},   chk_cnt, n);
        chk({tag, " rd_total"}, o_tot,   n);
        chk({tag, " err_cnt"},  o_ec,    32'(m_err));
        chk({tag, " err"},      o_err,   32'(has));
        chk({tag, " bad_exp"},  o_bexp,  bx);
        chk({tag, " bad_data"}, o_bdat,  bd);
        chk({tag, " ba_drop"},  drop,    0);
        chk({tag, " rd_viol"},  viol,    0);
    endtask

    initial begin
        int pushed;
        int expn;
        logic [15:0] w;

        // Empty FIFO: reset values, recovery wait, no reads.
        reset_hold();
        chk("rst rd_en",    o_rd_en, 0);
        chk("rst chk_valid", o_cv,   0);
        chk("rst burst",    o_ba,    0);
        chk("rst err",      o_err,   0);
        chk("rst err_cnt",  o_ec,    0);
        chk("rst rd_total", o_tot,   0);
        chk("rst bad_exp",  o_bexp,  0);
        chk("rst bad_data", o_bdat,  0);
        release_dut(1'b0);
        idle(500);
        chk("empty reads",    rd_cnt, 0);
        chk("empty rd_total", o_tot,  0);
        chk("empty burst",    o_ba,   0);
        // Threshold: 63 words must not start a burst, 64 must.
        for (int i = 0; i < 63; i++) push(16'(i + 1));
        idle(20);
        chk("thr63 reads", rd_cnt, 0);
        push(16'd64);
        run_until(64, 300);
        idle(5);
        model_check("thr64", 64);

        // Clean burst preloaded during reset: first read timing and contiguity.
        reset_hold();
        for (int i = 0; i < 64; i++) push(16'(i + 1));
        release_dut(1'b0);
        run_until(64, 400);
        idle(10);
        chk("clean first_rd", first_rd, INIT_WAIT + 2);
        chk("clean span",     last_rd - first_rd, 63);
        chk("clean ba_post",  ba_post, 0);
        model_check("clean", 64);

        // Stalled burst with extra words queued: still exactly one 64-read burst.
        reset_hold();
        for (int i = 0; i < 100; i++) push(16'(i + 1));
        release_dut(1'b0);
        run_until(20, 400);
        fe = 1'b1; drive();
        idle(3);
        fe = 1'b0; drive();
        run_until(50, 200);
        fe = 1'b1; drive();
        idle(1);
        fe = 1'b0; drive();
        run_until(64, 200);
        idle(80);
        chk("stall span",    last_rd - first_rd, 67);
        chk("stall ba_post", ba_post, 0);
        model_check("stall", 64);

        // Single corrupted word.
        reset_hold();
        for (int i = 0; i < 64; i++) push((i == 10) ? 16'h0063 : 16'(i + 1));
        release_dut(1'b0);
        run_until(64, 400);
        idle(5);
        chk("corr err_cnt",  o_ec,   1);
        chk("corr bad_exp",  o_bexp, 16'h000B);
        chk("corr bad_data", o_bdat, 16'h0063);
        model_check("corr", 64);

        // Sequence wrap through 16'hFFFF on the second instance.
        reset_hold();
        m_start = 16'hFFFE;
        for (int i = 0; i < 64; i++) push(16'hFFFE + 16'(i));
        release_dut(1'b1);
        run_until(64, 400);
        idle(5);
        model_check("wrap", 64);

        // Reset in the middle of a burst, then a full recovery wait again.
        reset_hold();
        for (int i = 0; i < 64; i++) push(16'(i + 1));
        release_dut(1'b0);
        run_until(30, 400);
        chk("mid cv before", o_cv, 1);
        chk("mid tot before", o_tot, 29);
        rst_a_n = 1'b0;
        #1;
        chk("mid rd_en",    o_rd_en, 0);
        chk("mid chk_valid", o_cv,   0);
        chk("mid rd_total", o_tot,   0);
        chk("mid burst",    o_ba,    0);
        reset_hold();
        for (int i = 0; i < 64; i++) push(16'(i + 1));
        release_dut(1'b0);
        run_until(64, 400);
        idle(5);
        chk("mid first_rd", first_rd, INIT_WAIT + 2);
        model_check("mid", 64);

        // Randomized pushes, corruption and stalls across several bursts.
        reset_hold();
        release_dut(1'b0);
        rand_en = 1'b1;
        pushed = 0;
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(20, 90);
            for (int i = 0; i < n; i++) begin
                w = m_start + 16'(sb.size());
                if ($urandom_range(0, 9) == 0) w = w ^ 16'($urandom_range(1, 16'hFFFF));
                push(w);
            end
            pushed += n;
            expn = (pushed / BURST_LEN) * BURST_LEN;
            run_until(expn, 3000);
            idle(8);
            model_check("rand", expn);
        end
        rand_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
